// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code decoding blocks: FSM state encodings
// and the supported word-width range.
package gray_pkg;

  // Encoding 2'd3 is unused and the FSM recovers from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Supported range for the WIDTH parameter of the Gray blocks.
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/gray_distance.sv
// Combinational Gray-step checker: gt1 is high when the two words differ in
// more than one bit, i.e. they are not the same code or adjacent codes.
module gray_distance #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt1
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] diff;
  logic [CNT_W-1:0] cnt;

  assign diff = a ^ b;

  // Population count of the differing bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(diff[i]);
    end
  end

  assign gt1 = (cnt > CNT_W'(1));

endmodule

// File: rtl/gray_to_bin_serial.sv
// Serial Gray-to-binary decoder. One Gray word is accepted over a valid/ready
// handshake and decoded MSB-first, one bit per clock. The binary result and a
// non-adjacent-step flag are held until the consumer takes them.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its data stable while valid is high and ready
// is low, and ready never depends combinationally on valid.
module gray_to_bin_serial
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             adj_err,
  output logic             busy,
  output state_t           state
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] prev_gray;
  logic             have_prev;
  logic             acc;
  logic             dist_gt1;
  logic             accept;
  logic             shift_bit;

  // Distance between the offered word and the last accepted word.
  gray_distance #(.WIDTH(WIDTH)) u_dist (
    .a   (gray_in),
    .b   (prev_gray),
    .gt1 (dist_gt1)
  );

  assign accept = in_valid & in_ready;

  // acc holds the previously decoded (more significant) binary bit, so
  // bin[idx] = bin[idx+1] ^ gray[idx]; it is 0 for the MSB, giving bin[MSB] = gray[MSB].
  assign shift_bit = acc ^ gray_q[idx];

  // Control FSM, decode shift and handshake outputs, all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      bin_out   <= '0;
      adj_err   <= 1'b0;
      idx       <= '0;
      gray_q    <= '0;
      prev_gray <= '0;
      have_prev <= 1'b0;
      acc       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            gray_q    <= gray_in;
            idx       <= IDX_W'(WIDTH - 1);
            bin_out   <= '0;
            acc       <= 1'b0;
            adj_err   <= have_prev & dist_gt1;
            prev_gray <= gray_in;
            have_prev <= 1'b1;
            state     <= ST_SHIFT;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          bin_out[idx] <= shift_bit;
          acc          <= shift_bit;
          if (idx == '0) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
